// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame shift register: parity modes, FSM state
// and shift-direction encodings, and the frame-length helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic {
    IDLE     = 1'b0,
    SHIFTING = 1'b1
  } state_t;

  typedef enum logic {
    DIR_RX = 1'b0,
    DIR_TX = 1'b1
  } dir_t;

  function automatic int frame_len(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Parity bit generator: XOR reduction of the data word, inverted for odd parity so
// that data plus parity always carries the requested count of ones.
module uart_parity_gen
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PARITY_EVEN
) (
  input  logic [DATA_BITS-1:0] data,
  output logic                 parity
);

  assign parity = (PARITY == PARITY_ODD) ? ~(^data) : (^data);

endmodule

// File: rtl/uart_frame_shift_register.sv
// One-frame UART shift register shared by TX (parallel load, serial out, LSB first)
// and RX (serial capture, decode, parity/framing check). Optional break detection
// is enabled by defining UART_SHIFT_BREAK_DETECT_EN.
module uart_frame_shift_register
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data_in_p,
  input  logic                 shift,
  input  logic                 data_in_s,
  output logic                 serial_out,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int FRAME_LEN = frame_len(DATA_BITS, PARITY, STOP_BITS);
  localparam int CW        = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(FRAME_LEN);

  state_t               state_reg, state_next;
  dir_t                 dir_reg, dir_next;
  logic [FRAME_LEN-1:0] frame_reg, frame_next;
  logic [CW-1:0]        count_reg, count_next;
  logic [DATA_BITS-1:0] data_out_reg, data_out_next;
  logic                 parity_err_reg, parity_err_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 done_reg, done_next;
  logic                 break_reg, break_next;

  logic [FRAME_LEN-1:0] shifted;
  logic [FRAME_LEN-1:0] tx_frame;
  logic [DATA_BITS-1:0] rx_data;
  logic [STOP_BITS-1:0] rx_stop;
  logic                 rx_parity_bad;
  logic                 rx_break;

  // Decode always looks at the post-shift value so completion can use it on the same edge.
  assign shifted = {data_in_s, frame_reg[FRAME_LEN-1:1]};
  assign rx_data = shifted[DATA_BITS:1];
  assign rx_stop = shifted[FRAME_LEN-1 -: STOP_BITS];

  generate
    if (PARITY != PARITY_NONE) begin : g_parity
      logic tx_parity;
      logic rx_parity;

      uart_parity_gen #(.DATA_BITS(DATA_BITS), .PARITY(PARITY)) u_tx_parity (
        .data   (data_in_p),
        .parity (tx_parity)
      );

      uart_parity_gen #(.DATA_BITS(DATA_BITS), .PARITY(PARITY)) u_rx_parity (
        .data   (rx_data),
        .parity (rx_parity)
      );

      assign tx_frame      = {{STOP_BITS{1'b1}}, tx_parity, data_in_p, 1'b0};
      assign rx_parity_bad = (rx_parity != shifted[DATA_BITS+1]);
    end else begin : g_no_parity
      assign tx_frame      = {{STOP_BITS{1'b1}}, data_in_p, 1'b0};
      assign rx_parity_bad = 1'b0;
    end
  endgenerate

`ifdef UART_SHIFT_BREAK_DETECT_EN
  assign rx_break = ~|shifted;
`else
  assign rx_break = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    dir_next        = dir_reg;
    frame_next      = frame_reg;
    count_next      = count_reg;
    data_out_next   = data_out_reg;
    parity_err_next = parity_err_reg;
    frame_err_next  = frame_err_reg;
    done_next       = 1'b0;
    break_next      = 1'b0;

    // A load always wins, aborting whatever frame is in flight.
    if (load) begin
      frame_next = tx_frame;
      dir_next   = DIR_TX;
      count_next = '0;
      state_next = SHIFTING;
    end else if (shift) begin
      if (state_reg == IDLE) begin
        if (!data_in_s) begin
          frame_next = shifted;
          count_next = CW'(1);
          dir_next   = DIR_RX;
          state_next = SHIFTING;
        end
      end else begin
        frame_next = shifted;
        count_next = count_reg + 1'b1;
        if (count_next == LAST_COUNT) begin
          state_next = IDLE;
          done_next  = 1'b1;
          if (dir_reg == DIR_RX) begin
            data_out_next = rx_data;
            if (rx_break) begin
              break_next = 1'b1;
            end else begin
              parity_err_next = rx_parity_bad;
              frame_err_next  = ~&rx_stop;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      dir_reg        <= DIR_RX;
      frame_reg      <= '1;
      count_reg      <= '0;
      data_out_reg   <= '0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      done_reg       <= 1'b0;
      break_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      dir_reg        <= dir_next;
      frame_reg      <= frame_next;
      count_reg      <= count_next;
      data_out_reg   <= data_out_next;
      parity_err_reg <= parity_err_next;
      frame_err_reg  <= frame_err_next;
      done_reg       <= done_next;
      break_reg      <= break_next;
    end
  end

  assign serial_out = frame_reg[0];
  assign data_out   = data_out_reg;
  assign busy       = (state_reg == SHIFTING);
  assign frame_done = done_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;
  assign break_det  = break_reg;

endmodule

// File: doc/uart_frame_shift_register.md
Name: uart_frame_shift_register

Overview:
Parametrised successor of the fixed 10-bit UART shift register. Holds one complete UART frame: start bit, DATA_BITS data bits, optional parity and 1-2 stop bits.
- TX: frame loaded in parallel, shifted out serially, LSB first.
- RX: frame captured serially, then extracted and checked for parity and framing errors.
- Sits between the baud-tick generator (drives `shift`) and the UART TX/RX control logic.

Parameters:
DATA_BITS, 8, data bits per frame (legal range 5..9)
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
clock  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
load  input  1  start a TX frame from data_in_p
data_in_p  input  DATA_BITS  parallel TX data
shift  input  1  one-cycle baud strobe; advances the frame by one bit
data_in_s  input  1  serial RX line (idle high)
serial_out  output  1  serial TX line
data_out  output  DATA_BITS  last received data word
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse when a frame completes
parity_err  output  1  parity mismatch on last RX frame
frame_err  output  1  stop bit(s) not 1 on last RX frame
break_det  output  1  break condition (optional feature)

Behaviour:
- FRAME_LEN = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS. The internal register is FRAME_LEN bits wide. The bit counter is clog2(FRAME_LEN+1) bits wide.
- Reset (reset = 0, asynchronous):
  - register = all ones; counter = 0; state = IDLE; dir = RX
  - serial_out = 1; data_out = 0
  - busy, frame_done, parity_err, frame_err, break_det = 0
- States: IDLE, SHIFTING. serial_out = register[0] at all times, so it reads 1 in IDLE.
- IDLE, load = 1:
  - register = {STOP_BITS ones, parity bit if enabled, data_in_p, 1'b0}
  - dir = TX; counter = 0; go to SHIFTING
- IDLE, shift = 1 with data_in_s = 0 (start bit), load = 0:
  - register = {data_in_s, register[FRAME_LEN-1:1]}
  - counter = 1; dir = RX; go to SHIFTING
- IDLE, shift = 1 with data_in_s = 1: no action.
- SHIFTING, each shift = 1:
  - register shifts right, data_in_s entering at the MSB; counter increments.
  - When counter reaches FRAME_LEN, return to IDLE and pulse frame_done for exactly one cycle, registered on the same edge.
- The counter target is the same in both directions: a TX frame completes on its FRAME_LEN-th strobe after load; an RX frame completes on its FRAME_LEN-th strobe including the start-bit strobe.
- On RX completion, on the same edge as frame_done:
  - data_out = register data field, taken from the post-shift value.
  - parity_err = computed parity != received parity bit; always 0 when PARITY = 0.
  - frame_err = any stop bit == 0.
  - Error flags hold until the next RX completion or reset.
- On TX completion: data_out and the error flags are unchanged.
- busy = (state == SHIFTING).
- Simultaneous events:
  - load and shift in the same cycle: load wins; the shift is ignored.
  - load during SHIFTING: current frame aborted, new TX frame loaded, counter = 0, no frame_done for the aborted frame.
- Reset mid-frame: immediate return to the reset state; the partial frame is discarded.
- Parity: odd => parity bit makes the total count of ones in data+parity odd; even => even.

Optional Feature:
Macro: UART_SHIFT_BREAK_DETECT_EN.
- Defined: an RX frame whose entire register is zero (data, parity and stop bits all 0) pulses break_det with frame_done. frame_err and parity_err are not updated for that frame; data_out is still updated to 0.
- Undefined: break_det is tied to 0; an all-zero frame is reported as frame_err = 1.

Decomposition:
- Package uart_pkg holds:
  - parity-mode constants PARITY_NONE / ODD / EVEN
  - state encoding (IDLE, SHIFTING)
  - constant function frame_len(DATA_BITS, PARITY, STOP_BITS)
- One sub-module, uart_parity_gen: XOR reduction plus odd/even selection, parametrised on DATA_BITS. It is instantiated twice: once for the TX parity bit, once for the RX check.

Test Plan:
- 8N1, load data_in_p = 0xA5, then 10 shift strobes -> serial_out = 0,1,0,1,0,0,1,0,1,1; frame_done pulses once, on the 10th strobe edge; busy falls on that same edge.
- 8E1, RX frame on data_in_s 0, 0,0,1,1,1,1,0,0, 0, 1 (11 strobes) -> data_out = 0x3C, parity_err = 0, frame_err = 0.
- Same frame with parity bit = 1 -> parity_err = 1. Same frame with stop bit = 0 -> frame_err = 1, data_out = 0x3C.
- 7O2, load = 1 and shift = 1 in the same cycle with data 0x55 -> strobe ignored; serial_out stays 0 (start bit); frame completes after exactly 11 further strobes.
- Reset (reset = 0) asserted after 4 strobes of an 8N1 RX frame -> all outputs return to reset values immediately; a fresh frame after release decodes correctly.
- UART_SHIFT_BREAK_DETECT_EN defined, 8N1, 10 zero bits on RX -> break_det = 1 for one cycle, frame_err = 0. Undefined -> break_det = 0, frame_err = 1.
